// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: front end of the snake movement block.
// Synchronises and debounces the four direction buttons and start/pause,
// runs the IDLE/RUN/PAUSE state machine, filters 180-degree reversals and
// commits one move code per game step.
//
// Ports:
//   clk        system clock (single domain)
//   rst        asynchronous active-low reset
//   btn_up/btn_down/btn_left/btn_right/btn_start
//              raw asynchronous active-high button levels
//   inmove[2:0] move code: 000 right, 001 up, 010 left, 011 down, 100 hold
//   step       one-cycle pulse on every game-step commit
//   running    high while in RUN

// Per-button input path: 2-flop synchroniser followed by a stability
// counter.  press fires in the cycle the debounced level is about to rise,
// so the FSM sees it 2 + DEBOUNCE_CYCLES edges after the raw edge.
module snake_dir_deb #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int            CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, lvl;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip  = (s2 != lvl) && (cnt == CMAX);
  assign press = flip && s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == lvl || flip) cnt <= '0;
      else                   cnt <= cnt + CW'(1);
      if (flip) lvl <= s2;
    end
  end
endmodule

module snake_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [2:0] inmove,
  output logic       step,
  output logic       running
);
  localparam int            NBTN = 5;
  localparam int            B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_START = 4;
  localparam int            TW   = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  // Direction codes; the opposite heading is the code with bit 1 flipped.
  localparam logic [1:0] DIR_RIGHT = 2'd0, DIR_UP = 2'd1, DIR_LEFT = 2'd2, DIR_DOWN = 2'd3;
  localparam logic [2:0] MV_HOLD   = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic [NBTN-1:0] raw, press;
  state_t          state;
  logic [1:0]      dir, pend, req, dir_eff;
  logic            pend_v, req_v, req_ok, store, enter_dir;
  logic [TW-1:0]   tcnt;
  logic            tick, tick_q, commit, p_start;

  assign raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NBTN; i++) begin : g_deb
    snake_dir_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .press(press[i])
    );
  end

  assign p_start = press[B_START];

  // Simultaneous presses: up > down > left > right.
  always_comb begin
    req_v = 1'b1;
    req   = DIR_RIGHT;
    if      (press[B_UP])    req = DIR_UP;
    else if (press[B_DOWN])  req = DIR_DOWN;
    else if (press[B_LEFT])  req = DIR_LEFT;
    else if (press[B_RIGHT]) req = DIR_RIGHT;
    else                     req_v = 1'b0;
  end

  // tick is registered once; the commit happens in the following cycle and
  // a start press in either cycle cancels it (pause wins).
  assign tick      = (state == RUN) && (tcnt == TMAX);
  assign commit    = (state == RUN) && !p_start && tick_q;
  // Requests are checked against the heading as it stands after this
  // cycle's commit, so a press can never reverse a freshly committed move.
  assign dir_eff   = (commit && pend_v) ? pend : dir;
  assign req_ok    = req_v && (req != (dir_eff ^ 2'b10));
  assign enter_dir = req_ok && (state == IDLE) && !p_start;
  assign store     = req_ok && ((state != IDLE) || p_start);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dir     <= DIR_RIGHT;
      pend    <= DIR_RIGHT;
      pend_v  <= 1'b0;
      tcnt    <= '0;
      tick_q  <= 1'b0;
      step    <= 1'b0;
      running <= 1'b0;
      inmove  <= MV_HOLD;
    end else begin
      step   <= commit;
      tick_q <= tick && !p_start;

      if (state == RUN && !p_start) tcnt <= (tcnt == TMAX) ? '0 : tcnt + TW'(1);
      else                          tcnt <= '0;

      if (commit) begin
        dir    <= dir_eff;
        pend_v <= 1'b0;
        inmove <= {1'b0, dir_eff};
      end
      // A press landing on the commit cycle becomes the next pending move.
      if (store) begin
        pend   <= req;
        pend_v <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (p_start) begin
            state   <= RUN;
            running <= 1'b1;
            inmove  <= {1'b0, dir};
          end else if (enter_dir) begin
            state   <= RUN;
            running <= 1'b1;
            dir     <= req;
            inmove  <= {1'b0, req};
          end
        end
        RUN: begin
          if (p_start) begin
            state   <= PAUSE;
            running <= 1'b0;
            inmove  <= MV_HOLD;
          end
        end
        PAUSE: begin
          if (p_start) begin
            state   <= RUN;
            running <= 1'b1;
            inmove  <= {1'b0, dir};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=10.
// A directed table walks through debounce, reversal, priority, and
// pause/resume; hand sequences cover start-on-tick and async reset; a random
// phase follows.  A behavioural model tracks expected outputs every cycle.
module tb_snake_dir_ctrl;
  localparam int DC = 4;
  localparam int TD = 10;

  localparam logic [4:0] B0 = 5'b00000, BU = 5'b00001, BD = 5'b00010,
                         BL = 5'b00100, BR = 5'b01000, BS = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
  logic [2:0] inmove;
  logic       step, running;

  int nvec = 0;
  int nerr = 0;

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(DC), .TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_start(btn_start),
    .inmove   (inmove),
    .step     (step),
    .running  (running)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Buttons are indexed {start,right,left,down,up} = bits 4..0.
  logic [4:0] smp0, smp1;     // raw samples from the previous two edges
  logic [4:0] lvl;            // debounced levels
  int         runlen [5];     // consecutive edges the synced value differed
  int         mode;           // 0 idle, 1 run, 2 pause
  int         head;           // committed heading 0 right,1 up,2 left,3 down
  int         pend;           // -1 when nothing pending
  int         age;            // edges spent in RUN since entry
  bit         due;            // a game step commits on the next edge
  logic [2:0] m_inmove;
  logic       m_step, m_running;

  task automatic mdl_reset();
    smp0 = '0; smp1 = '0; lvl = '0;
    for (int i = 0; i < 5; i++) runlen[i] = 0;
    mode = 0; head = 0; pend = -1; age = 0; due = 0;
    m_inmove = 3'b100; m_step = 1'b0; m_running = 1'b0;
  endtask

  task automatic mdl_edge(input logic [4:0] b);
    logic [4:0] syn, pr;
    int         req;
    bit         was_idle, tick_now;
    syn  = smp1;
    smp1 = smp0;
    smp0 = b;
    pr   = '0;
    for (int i = 0; i < 5; i++) begin
      if (syn[i] != lvl[i]) begin
        runlen[i]++;
        if (runlen[i] == DC) begin
          lvl[i]    = syn[i];
          runlen[i] = 0;
          pr[i]     = syn[i];
        end
      end else runlen[i] = 0;
    end
    req      = pr[0] ? 1 : pr[1] ? 3 : pr[2] ? 2 : pr[3] ? 0 : -1;
    was_idle = (mode == 0);
    m_step   = 1'b0;
    if (pr[4]) begin
      due = 0;
      age = 0;
      if (mode == 1) begin
        mode = 2; m_inmove = 3'b100; m_running = 1'b0;
      end else begin
        mode = 1; m_inmove = 3'(head); m_running = 1'b1;
      end
    end else if (mode == 1) begin
      tick_now = (age % TD) == TD - 1;
      if (due) begin
        if (pend >= 0) begin head = pend; pend = -1; end
        m_step   = 1'b1;
        m_inmove = 3'(head);
      end
      due = tick_now;
      age++;
    end
    if (req >= 0 && req != (head ^ 2)) begin
      if (was_idle && !pr[4]) begin
        mode = 1; head = req; m_inmove = 3'(req); m_running = 1'b1;
      end else pend = req;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [2:0] mv, input logic st, input logic rn);
    nvec++;
    if ({inmove, step, running} !== {mv, st, rn}) begin
      nerr++;
      $display("FAIL %s @%0t: got inmove=%b step=%b running=%b, want inmove=%b step=%b running=%b",
               name, $time, inmove, step, running, mv, st, rn);
    end
  endtask

  // One clock: drive buttons, let the edge pass, step the model, compare.
  task automatic cyc(input logic [4:0] b);
    {btn_start, btn_right, btn_left, btn_down, btn_up} = b;
    @(posedge clk);
    #1;
    if (!rst) mdl_reset();
    else      mdl_edge(b);
    chk("model", m_inmove, m_step, m_running);
  endtask

  task automatic hold(input logic [4:0] b, input int n);
    for (int k = 0; k < n; k++) cyc(b);
  endtask

  typedef struct {
    logic [4:0] btn;
    int         n;
    logic [2:0] mv;
    logic       st;
    logic       rn;
  } vec_t;

  vec_t tbl [38];

  initial begin
    // {buttons, cycles held, expected inmove/step/running at the last cycle}
    tbl[0]  = '{B0,      3, 3'b100, 1'b0, 1'b0};  // idle after reset
    tbl[1]  = '{BS,      3, 3'b100, 1'b0, 1'b0};  // 3-cycle glitch
    tbl[2]  = '{B0,      4, 3'b100, 1'b0, 1'b0};  // glitch ignored
    tbl[3]  = '{BS,      5, 3'b100, 1'b0, 1'b0};  // stable, still debouncing
    tbl[4]  = '{BS,      1, 3'b000, 1'b0, 1'b1};  // RUN on 6th cycle
    tbl[5]  = '{BS,      2, 3'b000, 1'b0, 1'b1};
    tbl[6]  = '{B0,      8, 3'b000, 1'b0, 1'b1};
    tbl[7]  = '{B0,      1, 3'b000, 1'b1, 1'b1};  // first step 11 later
    tbl[8]  = '{BL,      4, 3'b000, 1'b0, 1'b1};  // reversal of right
    tbl[9]  = '{B0,      6, 3'b000, 1'b1, 1'b1};  // step, still right
    tbl[10] = '{BU,      1, 3'b000, 1'b0, 1'b1};
    tbl[11] = '{BU | BL, 3, 3'b000, 1'b0, 1'b1};
    tbl[12] = '{BL,      1, 3'b000, 1'b0, 1'b1};  // up, then left rejected
    tbl[13] = '{B0,      5, 3'b001, 1'b1, 1'b1};
    tbl[14] = '{BL,      4, 3'b001, 1'b0, 1'b1};
    tbl[15] = '{B0,      6, 3'b010, 1'b1, 1'b1};  // heading left
    tbl[16] = '{BU | BD, 4, 3'b010, 1'b0, 1'b1};  // up beats down
    tbl[17] = '{B0,      6, 3'b001, 1'b1, 1'b1};
    tbl[18] = '{BR,      4, 3'b001, 1'b0, 1'b1};
    tbl[19] = '{B0,      6, 3'b000, 1'b1, 1'b1};  // heading right
    tbl[20] = '{BS,      4, 3'b000, 1'b0, 1'b1};  // pause press
    tbl[21] = '{B0,      2, 3'b100, 1'b0, 1'b0};  // paused
    tbl[22] = '{BD,      4, 3'b100, 1'b0, 1'b0};  // down while paused
    tbl[23] = '{B0,      4, 3'b100, 1'b0, 1'b0};
    tbl[24] = '{BS,      4, 3'b100, 1'b0, 1'b0};  // resume press
    tbl[25] = '{B0,      2, 3'b000, 1'b0, 1'b1};  // old heading restored
    tbl[26] = '{B0,     10, 3'b000, 1'b0, 1'b1};
    tbl[27] = '{B0,      1, 3'b011, 1'b1, 1'b1};  // pending down applies
    tbl[28] = '{BL,      4, 3'b011, 1'b0, 1'b1};
    tbl[29] = '{B0,      6, 3'b010, 1'b1, 1'b1};  // heading left
    tbl[30] = '{BU | BD, 4, 3'b010, 1'b0, 1'b1};
    tbl[31] = '{B0,      6, 3'b001, 1'b1, 1'b1};  // up priority
    tbl[32] = '{BR,      4, 3'b001, 1'b0, 1'b1};
    tbl[33] = '{B0,      6, 3'b000, 1'b1, 1'b1};  // heading right
    tbl[34] = '{BD,      1, 3'b000, 1'b0, 1'b1};
    tbl[35] = '{BD | BU, 3, 3'b000, 1'b0, 1'b1};
    tbl[36] = '{BU,      1, 3'b000, 1'b0, 1'b1};  // down then up
    tbl[37] = '{B0,      5, 3'b001, 1'b1, 1'b1};  // last valid wins

    mdl_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 3'b100, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 38; i++) begin
      hold(tbl[i].btn, tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].mv, tbl[i].st, tbl[i].rn);
    end

    // Start press lands on the tick cycle while a left move is pending.
    hold(BL, 3);
    cyc(BL | BS);
    hold(BS, 3);
    cyc(B0);  chk("tickstart_pre",   3'b001, 1'b0, 1'b1);
    cyc(B0);  chk("tickstart_pause", 3'b100, 1'b0, 1'b0);
    cyc(B0);  chk("tickstart_nostep", 3'b100, 1'b0, 1'b0);
    hold(B0, 3);
    hold(BS, 4);
    hold(B0, 2);  chk("resume_heading", 3'b001, 1'b0, 1'b1);
    hold(B0, 10); chk("resume_wait",    3'b001, 1'b0, 1'b1);
    cyc(B0);      chk("pending_kept",   3'b010, 1'b1, 1'b1);

    // Async reset mid-step while heading up.
    hold(BU, 4);
    hold(B0, 6);  chk("head_up", 3'b001, 1'b1, 1'b1);
    hold(B0, 4);  chk("pre_rst", 3'b001, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", 3'b100, 1'b0, 1'b0);
    mdl_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    hold(B0, 25); chk("idle_after_rst", 3'b100, 1'b0, 1'b0);

    // Random button segments with occasional resets.
    for (int s = 0; s < 250; s++) begin
      logic [4:0] b;
      int         n;
      b = 5'($urandom) & 5'($urandom);
      n = $urandom_range(1, 9);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        cyc(B0);
        rst = 1'b1;
      end
      hold(b, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
